send_bpm_link: RTL and testbench

Transmit-side packetizer for the BPM link: takes one 112-bit BPM reading (header field, X, Y, sum/status) and serializes it as a four-word AXI-stream packet into the Aurora transmitter. It sits in the Aurora TX user-clock domain, between the BPM readout pipeline and the Aurora TX user interface. It produces exactly the packet format the cell-controller link receiver checks. The Aurora core appends the CRC.

---
 rtl/send_bpm_link_if.sv | 11 +
 rtl/send_bpm_link.sv | 156 +++++++++++++++
 tb/tb_send_bpm_link.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/send_bpm_link_if.sv
// AXI-stream bundle carrying BPM link words toward the Aurora TX user interface.
// A word transfers on a rising clk edge where TVALID && TREADY; the source holds TDATA/TLAST until then.
interface send_bpm_link_if;
  logic [31:0] TDATA;
  logic        TVALID;
  logic        TLAST;
  logic        TREADY;

  modport master (output TDATA, output TVALID, output TLAST, input TREADY);
  modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/send_bpm_link.sv
// BPM link TX packetizer: one 112-bit reading becomes a four-word stream packet (A5BE header, X, Y, S).
// Optional one-entry pending slot for strobes arriving while busy: define SEND_BPM_LINK_PENDING_EN.
module send_bpm_link #(
  parameter string dbg = "false"
) (
  input  logic                   clk,
  input  logic                   reset,
  (* mark_debug = dbg *) input  logic         inputStrobe,
  (* mark_debug = dbg *) input  logic [111:0] inputData,
  (* mark_debug = dbg *) input  logic         inhibit,
  send_bpm_link_if.master        axis,
  (* mark_debug = dbg *) output logic         sentStrobe,
  (* mark_debug = dbg *) output logic         sentInvalid,
  (* mark_debug = dbg *) output logic         dropStrobe,
  output logic [2:0]             state_dbg
);

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_X, S_Y, S_S} state_t;

  localparam logic [15:0] SYNC   = 16'hA5BE;
  localparam logic [31:0] S_MASK = 32'hBFFF_FFFF;

  (* mark_debug = dbg *) state_t state;
  state_t       state_n;
  logic [95:0]  pkt, pkt_n;
  logic [31:0]  tdata, tdata_n;
  logic         tlast, tlast_n;
  logic         sent_q, sent_n;
  logic         sinv_q, sinv_n;
  logic         drop_q, drop_n;
  logic         accept, busy, hs, finish;
`ifdef SEND_BPM_LINK_PENDING_EN
  logic [111:0] pend, pend_n;
  logic         pend_valid, pend_valid_n;
  logic         take_direct;
`endif

  assign accept = inputStrobe && !inhibit;
  assign busy   = (state != S_IDLE);
  assign hs     = busy && axis.TREADY;
  assign finish = (state == S_S) && hs;

  assign axis.TVALID = busy;
  assign axis.TDATA  = tdata;
  assign axis.TLAST  = tlast;
  assign sentStrobe  = sent_q;
  assign sentInvalid = sinv_q;
  assign dropStrobe  = drop_q;
  assign state_dbg   = (dbg == "true") ? state : S_IDLE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      pkt    <= '0;
      tdata  <= '0;
      tlast  <= 1'b0;
      sent_q <= 1'b0;
      sinv_q <= 1'b0;
      drop_q <= 1'b0;
`ifdef SEND_BPM_LINK_PENDING_EN
      pend       <= '0;
      pend_valid <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      pkt    <= pkt_n;
      tdata  <= tdata_n;
      tlast  <= tlast_n;
      sent_q <= sent_n;
      sinv_q <= sinv_n;
      drop_q <= drop_n;
`ifdef SEND_BPM_LINK_PENDING_EN
      pend       <= pend_n;
      pend_valid <= pend_valid_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    pkt_n   = pkt;
    tdata_n = tdata;
    tlast_n = tlast;
    sent_n  = 1'b0;
    sinv_n  = 1'b0;
    drop_n  = 1'b0;
`ifdef SEND_BPM_LINK_PENDING_EN
    pend_n       = pend;
    pend_valid_n = pend_valid;
    take_direct  = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_n = S_HEADER;
          pkt_n   = inputData[95:0];
          tdata_n = {SYNC, inputData[111:96]};
          tlast_n = 1'b0;
        end
      end
      S_HEADER: begin
        if (hs) begin
          state_n = S_X;
          tdata_n = pkt[95:64];
        end
      end
      S_X: begin
        if (hs) begin
          state_n = S_Y;
          tdata_n = pkt[63:32];
        end
      end
      S_Y: begin
        if (hs) begin
          state_n = S_S;
          tdata_n = pkt[31:0] & S_MASK;
          tlast_n = 1'b1;
        end
      end
      S_S: begin
        if (hs) begin
          sent_n  = 1'b1;
          sinv_n  = pkt[31];
          tlast_n = 1'b0;
          state_n = S_IDLE;
`ifdef SEND_BPM_LINK_PENDING_EN
          // Older pending reading goes first; a strobe in this same cycle may start directly.
          if (pend_valid) begin
            state_n      = S_HEADER;
            pkt_n        = pend[95:0];
            tdata_n      = {SYNC, pend[111:96]};
            pend_valid_n = 1'b0;
          end else if (accept) begin
            state_n     = S_HEADER;
            pkt_n       = inputData[95:0];
            tdata_n     = {SYNC, inputData[111:96]};
            take_direct = 1'b1;
          end
`endif
        end
      end
      default: state_n = S_IDLE;
    endcase
`ifdef SEND_BPM_LINK_PENDING_EN
    // Newest reading wins the slot; a displaced one that was not just consumed is reported.
    if (busy && accept && !take_direct) begin
      pend_n       = inputData;
      pend_valid_n = 1'b1;
      drop_n       = pend_valid && !finish;
    end
`else
    drop_n = busy && accept;
`endif
  end

endmodule

// File: tb/tb_send_bpm_link.sv
// Bench for send_bpm_link: directed scenarios then random traffic, checked every cycle against a packet-level model.
module tb_send_bpm_link;

`ifdef SEND_BPM_LINK_PENDING_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         inputStrobe;
  logic [111:0] inputData;
  logic         inhibit;
  logic         sentStrobe;
  logic         sentInvalid;
  logic         dropStrobe;
  logic [2:0]   state_dbg;

  send_bpm_link_if bus ();

  send_bpm_link #(.dbg("true")) dut (
    .clk        (clk),
    .reset      (reset),
    .inputStrobe(inputStrobe),
    .inputData  (inputData),
    .inhibit    (inhibit),
    .axis       (bus),
    .sentStrobe (sentStrobe),
    .sentInvalid(sentInvalid),
    .dropStrobe (dropStrobe),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "watchdog");
  end

  // scoreboard / reference model state
  logic [31:0]  exp_q[$];
  logic [31:0]  seen_q[$];
  logic [111:0] pend_m;
  bit           pend_v;
  bit           exp_sent, exp_sinv, exp_drop;
  int           n_check, n_pass;
  int           sent_seen, drop_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_check++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic void push_pkt(input logic [111:0] d);
    exp_q.push_back({16'hA5BE, d[111:96]});
    exp_q.push_back(d[95:64]);
    exp_q.push_back(d[63:32]);
    exp_q.push_back({d[31], 1'b0, d[29:0]});
  endfunction

  // Packet-level model: the current packet is a queue of remaining words.
  function automatic void model_step(input logic r, input logic s, input logic [111:0] d,
                                     input logic inh, input logic rdy);
    bit acc, busy, fin;
    exp_sent = 0;
    exp_sinv = 0;
    exp_drop = 0;
    if (r) begin
      exp_q.delete();
      pend_v = 0;
      return;
    end
    acc  = s && !inh;
    busy = exp_q.size() != 0;
    fin  = busy && rdy && exp_q.size() == 1;
    if (busy && rdy) begin
      if (fin) begin
        exp_sent = 1;
        exp_sinv = exp_q[0][31];
      end
      void'(exp_q.pop_front());
    end
    if (fin && pend_v) begin
      push_pkt(pend_m);
      pend_v = 0;
    end
    if (acc && !busy) push_pkt(d);
    else if (acc && busy) begin
      if (!PEND) exp_drop = 1;
      else begin
        if (pend_v) exp_drop = 1;
        pend_m = d;
        pend_v = 1;
      end
    end
    if (fin && pend_v && exp_q.size() == 0) begin
      push_pkt(pend_m);
      pend_v = 0;
    end
  endfunction

  task automatic check_outputs();
    chk("tvalid", bus.TVALID, exp_q.size() != 0);
    chk("tlast", bus.TLAST, exp_q.size() == 1);
    if (exp_q.size() != 0) chk("tdata", bus.TDATA, exp_q[0]);
    chk("sent", sentStrobe, exp_sent);
    chk("sent_invalid", sentInvalid, exp_sinv);
    chk("drop", dropStrobe, exp_drop);
    if (sentStrobe === 1'b1) sent_seen++;
    if (dropStrobe === 1'b1) drop_seen++;
  endtask

  // driver: one clock cycle, inputs changed on the falling edge
  task automatic cycle(input logic r, input logic s, input logic [111:0] d,
                       input logic inh, input logic rdy);
    reset       = r;
    inputStrobe = s;
    inputData   = d;
    inhibit     = inh;
    bus.TREADY  = rdy;
    if (!r && bus.TVALID === 1'b1 && rdy) seen_q.push_back(bus.TDATA);
    @(posedge clk);
    model_step(r, s, d, inh, rdy);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drain(input logic inh);
    int k = 0;
    while ((exp_q.size() != 0 || pend_v) && k < 40) begin
      cycle(1'b0, 1'b0, '0, inh, 1'b1);
      k++;
    end
    chk("drain_bound", 32'(k), (k < 40) ? 32'(k) : 32'd0);
    cycle(1'b0, 1'b0, '0, inh, 1'b1);
  endtask

  task automatic clear_obs();
    seen_q.delete();
    sent_seen = 0;
    drop_seen = 0;
  endtask

  logic [111:0] pkt_a, pkt_inv, d_b, d_c, rnd;
  logic [3:0]   bp_pat;

  initial begin
    n_check = 0;
    n_pass  = 0;
    pend_v  = 0;
    pkt_a   = {16'h0012, 32'h00001000, 32'hFFFFF000, 32'h00ABCDEF};
    pkt_inv = {16'h3344, 32'h11111111, 32'h22222222, 32'hC0000005};
    d_b     = {16'h0B0B, 32'hB1B1B1B1, 32'hB2B2B2B2, 32'h0000000B};
    d_c     = {16'h0C0C, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'h0000000C};
    bp_pat  = 4'b1001;

    // reset values
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("rst_tdata", bus.TDATA, 32'h0);
    chk("rst_tvalid", bus.TVALID, 1'b0);
    chk("rst_tlast", bus.TLAST, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // single packet
    clear_obs();
    cycle(1'b0, 1'b1, pkt_a, 1'b0, 1'b1);
    drain(1'b0);
    chk("pkt1_words", seen_q.size(), 4);
    chk("pkt1_w0", seen_q[0], 32'hA5BE0012);
    chk("pkt1_w1", seen_q[1], 32'h00001000);
    chk("pkt1_w2", seen_q[2], 32'hFFFFF000);
    chk("pkt1_w3", seen_q[3], 32'h00ABCDEF);
    chk("pkt1_sent", sent_seen, 1);

    // backpressure: TREADY 1,0,0,1 repeating
    clear_obs();
    cycle(1'b0, 1'b1, pkt_a, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, '0, 1'b0, bp_pat[i % 4]);
    drain(1'b0);
    chk("bp_words", seen_q.size(), 4);
    chk("bp_w0", seen_q[0], 32'hA5BE0012);
    chk("bp_w3", seen_q[3], 32'h00ABCDEF);
    chk("bp_sent", sent_seen, 1);

    // invalid flag and forced bit 30
    clear_obs();
    cycle(1'b0, 1'b1, pkt_inv, 1'b0, 1'b1);
    drain(1'b0);
    chk("inv_w3", seen_q[3], 32'h80000005);
    chk("inv_sent", sent_seen, 1);

    // strobes while busy: A, then B at header+1, C at header+2
    clear_obs();
    cycle(1'b0, 1'b1, pkt_a, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, d_b, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, d_c, 1'b0, 1'b1);
    drain(1'b0);
`ifdef SEND_BPM_LINK_PENDING_EN
    chk("busy_drops", drop_seen, 1);
    chk("busy_words", seen_q.size(), 8);
    chk("busy_c_hdr", seen_q[4], 32'hA5BE0C0C);
    chk("busy_sent", sent_seen, 2);
`else
    chk("busy_drops", drop_seen, 2);
    chk("busy_words", seen_q.size(), 4);
    chk("busy_sent", sent_seen, 1);
`endif

    // inhibit at strobe time, then raised mid-packet
    clear_obs();
    cycle(1'b0, 1'b1, pkt_a, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("inh_words", seen_q.size(), 0);
    chk("inh_sent", sent_seen, 0);
    cycle(1'b0, 1'b1, pkt_inv, 1'b0, 1'b1);
    drain(1'b1);
    chk("inh_mid_words", seen_q.size(), 4);
    chk("inh_mid_sent", sent_seen, 1);

    // reset after word 1
    clear_obs();
    cycle(1'b0, 1'b1, pkt_a, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("rst_mid_tvalid", bus.TVALID, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("rst_mid_sent", sent_seen, 0);
    seen_q.delete();
    cycle(1'b0, 1'b1, pkt_inv, 1'b0, 1'b1);
    drain(1'b0);
    chk("rst_mid_hdr", seen_q[0], 32'hA5BE3344);
    chk("rst_mid_words", seen_q.size(), 4);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rnd = {16'($urandom), $urandom, $urandom, $urandom};
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0, rnd,
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
    end
    drain(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
